// File: rtl/fifo_param_mock.sv
// Behavioural, parametrised FIFO model standing in for vendor FIFO IP on
// simulation data paths. Supports standard (registered) or first-word-fall-
// through read data, sticky overflow/underflow flags, programmable almost
// thresholds and a synchronous flush.
//
// Request semantics: read and write are level requests sampled on each rising
// edge. A read is accepted when the FIFO is not empty. A write is accepted when
// the FIFO is not full, or when a read is accepted in the same cycle. A
// rejected request changes nothing except its sticky error flag. While flush
// is high, both requests are ignored and raise no flag.
module fifo_param_mock #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  output logic                       empty,
  output logic                       almost_empty,
  input  logic                       read,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       write,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clear
);

  localparam int PTR_BITS = $clog2(DEPTH);

  // Constants sized to the counter/pointer widths so every compare and
  // increment is width-exact.
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS:0]   CNT_AF   = (PTR_BITS + 1)'(AF_LEVEL);
  localparam logic [PTR_BITS:0]   CNT_AE   = (PTR_BITS + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]   r_wptr;
  logic [PTR_BITS-1:0]   r_rptr;
  logic [PTR_BITS:0]     r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_ovf_evt;
  logic w_unf_evt;

  // Status decode straight from the occupancy counter.
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_FULL);
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= CNT_AF);
  assign almost_empty = (r_count <= CNT_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Accept/reject decisions; flush and reset suppress every request.
  assign w_rd_ok   = read & ~w_empty & ~flush & ~reset;
  assign w_wr_ok   = write & (~w_full | w_rd_ok) & ~flush & ~reset;
  assign w_unf_evt = read & w_empty & ~flush & ~reset;
  assign w_ovf_evt = write & w_full & ~w_rd_ok & ~flush & ~reset;

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointer wrap is the natural power-of-two rollover.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a fresh error outranks err_clear; flush holds them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!flush) begin
      r_overflow  <= (r_overflow  & ~err_clear) | w_ovf_evt;
      r_underflow <= (r_underflow & ~err_clear) | w_unf_evt;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is shown continuously; meaningless while empty.
      assign rdata = r_mem[r_rptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rdata;

      // Registered read data, loaded only on an accepted read, else held.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata <= '0;
        end else if (w_rd_ok) begin
          r_rdata <= r_mem[r_rptr];
        end
      end

      assign rdata = r_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param_mock.sv
// Directed bench for fifo_param_mock: a 4-deep standard-read instance and an
// 8-deep FWFT instance with custom almost thresholds, sharing clock and reset.
module tb_fifo_param_mock;

  logic clk;
  logic reset;

  // Instance 0: DEPTH=4, FWFT=0, AF_LEVEL=3 (default DEPTH-1), AE_LEVEL=1
  logic       rd0, wr0, fl0, ec0;
  logic [7:0] wd0;
  logic       e0, ae0, f0, af0, ov0, un0;
  logic [7:0] rdat0;
  logic [2:0] cnt0;

  // Instance 1: DEPTH=8, FWFT=1, AF_LEVEL=6, AE_LEVEL=2
  logic       rd1, wr1, fl1, ec1;
  logic [7:0] wd1;
  logic       e1, ae1, f1, af1, ov1, un1;
  logic [7:0] rdat1;
  logic [3:0] cnt1;

  int n_tests;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  fifo_param_mock #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(fl0),
    .empty(e0), .almost_empty(ae0), .read(rd0), .rdata(rdat0),
    .full(f0), .almost_full(af0), .write(wr0), .wdata(wd0),
    .count(cnt0), .overflow(ov0), .underflow(un0), .err_clear(ec0)
  );

  fifo_param_mock #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut1 (
    .clk(clk), .reset(reset), .flush(fl1),
    .empty(e1), .almost_empty(ae1), .read(rd1), .rdata(rdat1),
    .full(f1), .almost_full(af1), .write(wr1), .wdata(wd1),
    .count(cnt1), .overflow(ov1), .underflow(un1), .err_clear(ec1)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on instance 0; outputs sampled 1 time unit after the edge.
  task automatic cyc0(input logic rd, input logic wr, input logic [7:0] wd,
                      input logic fl, input logic ec);
    rd0 = rd; wr0 = wr; wd0 = wd; fl0 = fl; ec0 = ec;
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0; fl0 = 1'b0; ec0 = 1'b0;
  endtask

  // One clock of stimulus on instance 1.
  task automatic cyc1(input logic rd, input logic wr, input logic [7:0] wd,
                      input logic fl, input logic ec);
    rd1 = rd; wr1 = wr; wd1 = wd; fl1 = fl; ec1 = ec;
    @(posedge clk); #1;
    rd1 = 1'b0; wr1 = 1'b0; fl1 = 1'b0; ec1 = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rd0 = 0; wr0 = 0; fl0 = 0; ec0 = 0; wd0 = '0;
    rd1 = 0; wr1 = 0; fl1 = 0; ec1 = 0; wd1 = '0;

    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst0_count", 32'(cnt0), 32'd0);
    check("rst0_empty", 32'(e0), 32'd1);
    check("rst0_full", 32'(f0), 32'd0);
    check("rst0_ae", 32'(ae0), 32'd1);
    check("rst0_af", 32'(af0), 32'd0);
    check("rst0_ovf", 32'(ov0), 32'd0);
    check("rst0_unf", 32'(un0), 32'd0);
    check("rst0_rdata", 32'(rdat0), 32'h00);
    check("rst1_count", 32'(cnt1), 32'd0);
    check("rst1_empty", 32'(e1), 32'd1);
    check("rst1_ae", 32'(ae1), 32'd1);

    // Basic write/read with one-cycle registered read data
    cyc0(0, 1, 8'hA5, 0, 0);
    cyc0(0, 1, 8'h5A, 0, 0);
    check("t1_count2", 32'(cnt0), 32'd2);
    check("t1_not_empty", 32'(e0), 32'd0);
    check("t1_ae_at2", 32'(ae0), 32'd0);
    cyc0(1, 0, 8'h00, 0, 0);
    check("t1_rd1_data", 32'(rdat0), 32'hA5);
    check("t1_rd1_count", 32'(cnt0), 32'd1);
    check("t1_ae_at1", 32'(ae0), 32'd1);
    cyc0(1, 0, 8'h00, 0, 0);
    check("t1_rd2_data", 32'(rdat0), 32'h5A);
    check("t1_empty_after", 32'(e0), 32'd1);
    cyc0(0, 0, 8'h00, 0, 0);
    check("t1_rdata_held", 32'(rdat0), 32'h5A);

    // Fill to full, then an overflowing write
    for (int i = 1; i <= 4; i++) begin
      cyc0(0, 1, 8'(i * 8'h11), 0, 0);
      exp_q.push_back(8'(i * 8'h11));
      if (i == 3) begin
        check("t2_af_at3", 32'(af0), 32'd1);
        check("t2_not_full_at3", 32'(f0), 32'd0);
      end
    end
    check("t2_full", 32'(f0), 32'd1);
    check("t2_count4", 32'(cnt0), 32'd4);
    cyc0(0, 1, 8'h55, 0, 0);
    check("t2_ovf_set", 32'(ov0), 32'd1);
    check("t2_count_held", 32'(cnt0), 32'd4);
    cyc0(0, 0, 8'h00, 0, 1);
    check("t2_ovf_cleared", 32'(ov0), 32'd0);

    // Read+write on full is accepted on both sides
    cyc0(1, 1, 8'h66, 0, 0);
    exp_v = exp_q.pop_front();
    exp_q.push_back(8'h66);
    check("t4_rw_count", 32'(cnt0), 32'd4);
    check("t4_rw_ovf", 32'(ov0), 32'd0);
    check("t4_rw_rdata", 32'(rdat0), 32'(exp_v));
    // Drain across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      cyc0(1, 0, 8'h00, 0, 0);
      exp_v = exp_q.pop_front();
      check($sformatf("t4_drain%0d", i), 32'(rdat0), 32'(exp_v));
    end
    check("t4_drained_empty", 32'(e0), 32'd1);

    // Underflow handling
    cyc0(1, 0, 8'h00, 0, 0);
    check("t3_unf_set", 32'(un0), 32'd1);
    check("t3_unf_count", 32'(cnt0), 32'd0);
    check("t3_unf_rdata_held", 32'(rdat0), 32'h66);
    cyc0(1, 1, 8'h77, 0, 0);
    check("t3_rw_empty_count", 32'(cnt0), 32'd1);
    check("t3_rw_empty_unf", 32'(un0), 32'd1);
    check("t3_rw_empty_rdata", 32'(rdat0), 32'h66);
    cyc0(1, 0, 8'h00, 0, 1);
    check("t3_read_after_unf", 32'(rdat0), 32'h77);
    check("t3_unf_cleared", 32'(un0), 32'd0);
    cyc0(1, 0, 8'h00, 0, 1);
    check("t3_clear_vs_new_err", 32'(un0), 32'd1);
    cyc0(0, 0, 8'h00, 0, 1);
    check("t3_clear_only", 32'(un0), 32'd0);

    // Flush on the standard-read instance holds rdata
    cyc0(0, 1, 8'hAB, 0, 0);
    cyc0(0, 1, 8'hCD, 0, 0);
    cyc0(1, 1, 8'hEF, 1, 0);
    check("f0_count", 32'(cnt0), 32'd0);
    check("f0_empty", 32'(e0), 32'd1);
    check("f0_rdata_held", 32'(rdat0), 32'h77);
    check("f0_no_unf", 32'(un0), 32'd0);
    cyc0(0, 1, 8'h12, 0, 0);
    cyc0(1, 0, 8'h00, 0, 0);
    check("f0_post_flush_data", 32'(rdat0), 32'h12);

    // FWFT instance: head word visible without a read
    cyc1(0, 1, 8'h11, 0, 0);
    check("t5_fwft_show", 32'(rdat1), 32'h11);
    check("t5_count1", 32'(cnt1), 32'd1);
    cyc1(0, 1, 8'h22, 0, 0);
    check("t5_head_stays", 32'(rdat1), 32'h11);
    cyc1(1, 0, 8'h00, 0, 0);
    check("t5_pop_next", 32'(rdat1), 32'h22);
    check("t5_pop_count", 32'(cnt1), 32'd1);
    cyc1(1, 0, 8'h00, 0, 0);
    check("t5_empty", 32'(e1), 32'd1);
    cyc1(1, 0, 8'h00, 0, 0);
    check("t5_unf", 32'(un1), 32'd1);

    // Thresholds then a flush mid-fill
    for (int i = 0; i < 6; i++) begin
      cyc1(0, 1, 8'(8'h30 + i), 0, 0);
      if (i == 1) check("t6_ae_at2", 32'(ae1), 32'd1);
      if (i == 2) check("t6_ae_at3", 32'(ae1), 32'd0);
      if (i == 4) check("t6_af_at5", 32'(af1), 32'd0);
    end
    check("t6_af_at6", 32'(af1), 32'd1);
    check("t6_count6", 32'(cnt1), 32'd6);
    check("t6_full_at6", 32'(f1), 32'd0);
    check("t6_head", 32'(rdat1), 32'h30);
    cyc1(1, 1, 8'hEE, 1, 0);
    check("t6_flush_count", 32'(cnt1), 32'd0);
    check("t6_flush_empty", 32'(e1), 32'd1);
    check("t6_flush_ae", 32'(ae1), 32'd1);
    check("t6_flush_af", 32'(af1), 32'd0);
    check("t6_flush_unf_held", 32'(un1), 32'd1);
    check("t6_flush_ovf", 32'(ov1), 32'd0);
    cyc1(0, 1, 8'h99, 0, 0);
    check("t6_post_flush_head", 32'(rdat1), 32'h99);
    check("t6_post_flush_count", 32'(cnt1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
